writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/mips_pkg.sv | 11 +
 rtl/load_extend.sv | 28 ++
 rtl/writeback_stage.sv | 105 ++++++++++
 tb/tb_writeback_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared writeback constants: result-source indices and load-size encodings.
package mips_pkg;
    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;
    localparam int SRC_PC4 = 2;
    localparam int SRC_LUI = 3;

    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;
endpackage

// File: rtl/load_extend.sv
// Aligns a sub-word load within the fetched word and sign/zero extends it.
// Only instantiated when WB_LOAD_EXT_EN is defined.
module load_extend
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] word_i,
    input  logic [1:0]       size_i,
    input  logic             unsigned_i,
    input  logic [1:0]       offset_i,
    output logic [WIDTH-1:0] data_o
);
    logic [WIDTH-1:0] byte_sh;
    logic [WIDTH-1:0] half_sh;

    assign byte_sh = word_i >> {offset_i, 3'b000};
    assign half_sh = word_i >> (offset_i[1] ? 16 : 0);

    always_comb begin
        data_o = word_i;
        case (size_i)
            LD_BYTE: data_o = {{(WIDTH-8){~unsigned_i & byte_sh[7]}}, byte_sh[7:0]};
            LD_HALF: data_o = {{(WIDTH-16){~unsigned_i & half_sh[15]}}, half_sh[15:0]};
            default: data_o = word_i;
        endcase
    end
endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: selects a result source and queues it in a 2-entry in-order
// buffer towards the register file. Define WB_LOAD_EXT_EN to align/extend loads.
module writeback_stage
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int RADDR = 5,
    localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       sel,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [RADDR-1:0]      rd_addr,
    input  logic                  reg_write,
    input  logic [1:0]            ld_size,
    input  logic                  ld_unsigned,
    input  logic [1:0]            ld_offset,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [WIDTH-1:0]      wb_data,
    output logic [RADDR-1:0]      wb_addr,
    output logic                  wb_we
);
    logic [WIDTH-1:0] mem_data;
    logic [WIDTH-1:0] sel_data;

`ifdef WB_LOAD_EXT_EN
    load_extend #(.WIDTH(WIDTH)) u_load_extend (
        .word_i     (src_data[SRC_MEM*WIDTH +: WIDTH]),
        .size_i     (ld_size),
        .unsigned_i (ld_unsigned),
        .offset_i   (ld_offset),
        .data_o     (mem_data)
    );
`else
    logic unused_ld;
    assign unused_ld = ^{ld_size, ld_unsigned, ld_offset};
    assign mem_data  = src_data[SRC_MEM*WIDTH +: WIDTH];
`endif

    // Out-of-range selects fall through to zero.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SELW'(k))
                sel_data = (k == SRC_MEM) ? mem_data : src_data[k*WIDTH +: WIDTH];
        end
    end

    // Slot 0 is always the head; a retire shifts slot 1 down.
    logic [WIDTH-1:0] data_q [2];
    logic [WIDTH-1:0] data_d [2];
    logic [RADDR-1:0] addr_q [2];
    logic [RADDR-1:0] addr_d [2];
    logic [1:0]       we_q, we_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop, slot;

    assign in_ready = (count_q != 2'd2);
    assign wb_valid = (count_q != 2'd0);
    assign push     = in_valid & in_ready;
    assign pop      = wb_valid & wb_ready;
    assign slot     = (count_q == 2'd1) & ~pop;

    always_comb begin
        data_d  = data_q;
        addr_d  = addr_q;
        we_d    = we_q;
        count_d = count_q + 2'(push) - 2'(pop);
        if (pop) begin
            data_d[0] = data_q[1];
            addr_d[0] = addr_q[1];
            we_d[0]   = we_q[1];
        end
        if (push) begin
            data_d[slot] = sel_data;
            addr_d[slot] = rd_addr;
            we_d[slot]   = reg_write & (rd_addr != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            we_q    <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            we_q    <= we_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    assign wb_data = wb_valid ? data_q[0] : '0;
    assign wb_addr = wb_valid ? addr_q[0] : '0;
    assign wb_we   = wb_valid & we_q[0];
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage; expectations follow WB_LOAD_EXT_EN.
module tb_writeback_stage;
    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, reg_write, ld_unsigned;
    logic [1:0]   sel, ld_size, ld_offset;
    logic [127:0] src_data;
    logic [4:0]   rd_addr, wb_addr;
    logic         wb_valid, wb_ready, wb_we;
    logic [31:0]  wb_data;
    int           n_chk = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .src_data(src_data), .rd_addr(rd_addr), .reg_write(reg_write),
        .ld_size(ld_size), .ld_unsigned(ld_unsigned), .ld_offset(ld_offset),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_addr(wb_addr), .wb_we(wb_we)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [1:0] s, input logic [4:0] rd, input logic rw);
        in_valid  = 1'b1;
        sel       = s;
        rd_addr   = rd;
        reg_write = rw;
    endtask

    logic [31:0] exp_signed, exp_unsigned, exp_half, exp_word;

    initial begin
        rst = 1'b0; in_valid = 1'b0; sel = 2'd0; src_data = '0; rd_addr = '0;
        reg_write = 1'b0; ld_size = 2'b10; ld_unsigned = 1'b0; ld_offset = 2'd0;
        wb_ready = 1'b1;
        @(negedge clk);

        // Reset held two cycles while an entry is offered
        rst = 1'b1; offer(2'd0, 5'd7, 1'b1);
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_valid", 32'(wb_valid), 32'd0);
        chk("rst_we",    32'(wb_we),    32'd0);
        chk("rst_data",  wb_data,       32'd0);
        chk("rst_addr",  32'(wb_addr),  32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Source select
        src_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        offer(2'd2, 5'd5, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("sel2_valid", 32'(wb_valid), 32'd1);
        chk("sel2_data",  wb_data,       32'h33333333);
        chk("sel2_addr",  32'(wb_addr),  32'd5);
        chk("sel2_we",    32'(wb_we),    32'd1);
        tick();
        chk("sel2_drain", 32'(wb_valid), 32'd0);
        chk("drain_data", wb_data,       32'd0);
        offer(2'd3, 5'd9, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("sel3_data", wb_data,      32'h44444444);
        chk("sel3_we",   32'(wb_we),   32'd0);
        offer(2'd0, 5'd1, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("sel0_data", wb_data, 32'h11111111);
        tick();

        // Zero register never writes
        offer(2'd0, 5'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("zreg_valid", 32'(wb_valid), 32'd1);
        chk("zreg_we",    32'(wb_we),    32'd0);
        tick();

        // Backpressure: three back-to-back offers with consumer stalled
        wb_ready = 1'b0;
        src_data[31:0] = 32'hA;
        offer(2'd0, 5'd10, 1'b1);
        tick();
        chk("bp_ready1", 32'(in_ready), 32'd1);
        src_data[31:0] = 32'hB; rd_addr = 5'd11;
        tick();
        chk("bp_ready2", 32'(in_ready), 32'd0);
        src_data[31:0] = 32'hC; rd_addr = 5'd12;
        tick();
        chk("bp_held_rdy",  32'(in_ready), 32'd0);
        chk("bp_head_addr", 32'(wb_addr),  32'd10);
        chk("bp_head_data", wb_data,       32'hA);
        wb_ready = 1'b1;
        tick();
        chk("bp_out2_addr", 32'(wb_addr),  32'd11);
        chk("bp_out2_data", wb_data,       32'hB);
        chk("bp_rdy_back",  32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_out3_addr", 32'(wb_addr), 32'd12);
        chk("bp_out3_data", wb_data,      32'hC);
        tick();
        chk("bp_empty", 32'(wb_valid), 32'd0);

        // Load extension on source 1
`ifdef WB_LOAD_EXT_EN
        exp_signed = 32'hFFFFFF80; exp_unsigned = 32'h00000080;
        exp_half   = 32'hFFFF8001; exp_word     = 32'h80010000;
`else
        exp_signed = 32'h000080FF; exp_unsigned = 32'h000080FF;
        exp_half   = 32'h80010000; exp_word     = 32'h80010000;
`endif
        src_data[63:32] = 32'h000080FF;
        ld_size = 2'b00; ld_offset = 2'd1; ld_unsigned = 1'b0;
        offer(2'd1, 5'd3, 1'b1);
        tick();
        chk("ld_byte_s", wb_data, exp_signed);
        ld_unsigned = 1'b1;
        tick();
        chk("ld_byte_u", wb_data, exp_unsigned);
        src_data[63:32] = 32'h80010000;
        ld_size = 2'b01; ld_offset = 2'd2; ld_unsigned = 1'b0;
        tick();
        chk("ld_half_s", wb_data, exp_half);
        ld_size = 2'b10; ld_offset = 2'd3;
        tick();
        in_valid = 1'b0;
        chk("ld_word", wb_data, exp_word);
        tick();

        // Streaming one entry per cycle
        for (int k = 1; k <= 8; k++) begin
            offer(2'd0, 5'(k), 1'b1);
            tick();
            chk("strm_valid", 32'(wb_valid), 32'd1);
            chk("strm_addr",  32'(wb_addr),  32'(k));
        end
        in_valid = 1'b0;
        tick();
        chk("strm_done", 32'(wb_valid), 32'd0);

        // Reset mid-operation discards held and offered entries
        wb_ready = 1'b0;
        offer(2'd0, 5'd20, 1'b1);
        tick(); tick();
        chk("mid_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("mid_rst_valid", 32'(wb_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_addr",  32'(wb_addr),  32'd0);
        tick();
        chk("mid_rst_stay", 32'(wb_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
